// File: rtl/tlut_matmul_engine_pkg.sv
// Shared types and helpers for the temporal-LUT matrix engine.
// Holds the FSM state encoding and the accumulator width rule.
package tlut_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} tlut_state_e;

    function automatic int min_acc_w(int in_w, int wt_w, int inner, int sgn);
        return in_w + wt_w + $clog2(inner) + sgn;
    endfunction

endpackage

// File: rtl/tlut_matmul_engine_if.sv
// Operand/result bundle between a producer/consumer and the engine.
// The master drives operands and accepts results; the engine is the slave.
interface tlut_matmul_engine_if #(
    parameter int ROWS  = 2,
    parameter int INNER = 2,
    parameter int COLS  = 2,
    parameter int IN_W  = 4,
    parameter int WT_W  = 4,
    parameter int ACC_W = IN_W + WT_W + $clog2(INNER)
);
    logic                        start;
    logic                        ready;
    logic [ROWS*INNER*IN_W-1:0]  a_in;
    logic [INNER*COLS*WT_W-1:0]  w_in;
    logic [ROWS*COLS*ACC_W-1:0]  c_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic [IN_W-1:0]             cnt_out;

    modport master (
        output start, a_in, w_in, out_ready,
        input  ready, c_out, out_valid, busy, cnt_out
    );

    modport slave (
        input  start, a_in, w_in, out_ready,
        output ready, c_out, out_valid, busy, cnt_out
    );
endinterface

// File: rtl/tlut_matmul_engine_dot_slice.sv
// One output lane: rate-coded compare per inner term, masked weights,
// balanced adder tree and the lane accumulator.
module tlut_dot_slice #(
    parameter int INNER     = 2,
    parameter int IN_W      = 4,
    parameter int WT_W      = 4,
    parameter int ACC_W     = 9,
    parameter int WT_SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [IN_W-1:0]         cnt_i,
    input  logic [INNER*IN_W-1:0]   a_i,
    input  logic [INNER*WT_W-1:0]   w_i,
    output logic [ACC_W-1:0]        acc_o
);
    localparam int P = 1 << $clog2(INNER);

    function automatic logic [ACC_W-1:0] ext(logic [WT_W-1:0] w);
        if (WT_SIGNED != 0) return ACC_W'($signed(w));
        else                return ACC_W'(w);
    endfunction

    // Heap-ordered tree: leaves at [P..2P-1], root at [1]
    logic [ACC_W-1:0] node [1:2*P-1];
    logic [ACC_W-1:0] acc_q, acc_d;

    for (genvar k = 0; k < P; k++) begin : g_leaf
        if (k < INNER) begin : g_real
            assign node[P+k] = (cnt_i < a_i[k*IN_W +: IN_W])
                             ? ext(w_i[k*WT_W +: WT_W]) : '0;
        end else begin : g_pad
            assign node[P+k] = '0;
        end
    end

    for (genvar i = 1; i < P; i++) begin : g_tree
        assign node[i] = node[2*i] + node[2*i+1];
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i)     acc_d = '0;
        else if (en_i) acc_d = acc_q + node[1];
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/tlut_matmul_engine.sv
// Temporal-LUT matrix multiplier: C = A * W with A rate-coded
// against a shared counter, one accumulating lane per output.
module tlut_matmul_engine
    import tlut_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int INNER      = 2,
    parameter int COLS       = 2,
    parameter int IN_W       = 4,
    parameter int WT_W       = 4,
    parameter int WT_SIGNED  = 0,
    parameter int EARLY_TERM = 1,
    parameter int ACC_W      = IN_W + WT_W + $clog2(INNER) + WT_SIGNED
) (
    input logic                 clk,
    input logic                 rst,
    tlut_matmul_engine_if.slave bus
);
    localparam int NA = ROWS * INNER;

    if (ACC_W < min_acc_w(IN_W, WT_W, INNER, WT_SIGNED)) begin : g_acc_chk
        $error("ACC_W below minimum for these dimensions");
    end

    tlut_state_e                state_q, state_d;
    logic [IN_W-1:0]            cnt_q, cnt_d;
    logic [IN_W-1:0]            run_len_q, run_len_d;
    logic [NA*IN_W-1:0]         a_q;
    logic [INNER*COLS*WT_W-1:0] w_q;
    logic [IN_W-1:0]            max_a;
    logic                       load, clr, en;
    logic [ROWS*COLS*ACC_W-1:0] c_flat;

    always_comb begin
        max_a = '0;
        for (int i = 0; i < NA; i++) begin
            if (bus.a_in[i*IN_W +: IN_W] > max_a)
                max_a = bus.a_in[i*IN_W +: IN_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_len_d = run_len_q;
        load      = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    clr       = 1'b1;
                    cnt_d     = '0;
                    run_len_d = (EARLY_TERM != 0) ? max_a : {IN_W{1'b1}};
                    state_d   = (run_len_d == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                en = 1'b1;
                // Counter parks on the last value so it can never wrap
                if (cnt_q == run_len_q - IN_W'(1)) state_d = S_DONE;
                else                                cnt_d   = cnt_q + IN_W'(1);
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            run_len_q <= '0;
            a_q       <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_len_q <= run_len_d;
            if (load) begin
                a_q <= bus.a_in;
                w_q <= bus.w_in;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            logic [INNER*WT_W-1:0] w_col;
            logic [ACC_W-1:0]      acc;

            for (genvar k = 0; k < INNER; k++) begin : g_k
                assign w_col[k*WT_W +: WT_W] = w_q[(k*COLS+c)*WT_W +: WT_W];
            end

            tlut_dot_slice #(
                .INNER(INNER), .IN_W(IN_W), .WT_W(WT_W),
                .ACC_W(ACC_W), .WT_SIGNED(WT_SIGNED)
            ) u_slice (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr),
                .en_i  (en),
                .cnt_i (cnt_q),
                .a_i   (a_q[r*INNER*IN_W +: INNER*IN_W]),
                .w_i   (w_col),
                .acc_o (acc)
            );

            assign c_flat[(r*COLS+c)*ACC_W +: ACC_W] = acc;
        end
    end

    assign bus.c_out     = c_flat;
    assign bus.ready     = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.cnt_out   = cnt_q;
endmodule

// File: tb/tb_tlut_matmul_engine.sv
// Bench for the TLUT matrix engine: unsigned, signed full-run and
// randomised large-dimension instances against a scoreboard.
module tb_tlut_matmul_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlut_matmul_engine_if #(.ROWS(2), .INNER(2), .COLS(2), .IN_W(4), .WT_W(4), .ACC_W(9))  i0();
    tlut_matmul_engine_if #(.ROWS(2), .INNER(2), .COLS(2), .IN_W(4), .WT_W(4), .ACC_W(10)) i1();
    tlut_matmul_engine_if #(.ROWS(3), .INNER(5), .COLS(4), .IN_W(6), .WT_W(5), .ACC_W(15)) i2();

    tlut_matmul_engine #(.ROWS(2), .INNER(2), .COLS(2), .IN_W(4), .WT_W(4),
        .WT_SIGNED(0), .EARLY_TERM(1), .ACC_W(9)) u0 (.clk(clk), .rst(rst), .bus(i0));
    tlut_matmul_engine #(.ROWS(2), .INNER(2), .COLS(2), .IN_W(4), .WT_W(4),
        .WT_SIGNED(1), .EARLY_TERM(0), .ACC_W(10)) u1 (.clk(clk), .rst(rst), .bus(i1));
    tlut_matmul_engine #(.ROWS(3), .INNER(5), .COLS(4), .IN_W(6), .WT_W(5),
        .WT_SIGNED(1), .EARLY_TERM(1), .ACC_W(15)) u2 (.clk(clk), .rst(rst), .bus(i2));

    typedef struct {
        int a[4];
        int w[4];
        int c[4];
        int lat;
    } vec_t;

    typedef struct {
        int c[12];
    } exp_t;

    vec_t tbl[4];
    exp_t q0[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run0(input vec_t v, input bit hold);
        exp_t e;
        int   cyc;
        int   mx;
        for (int i = 0; i < 4; i++) e.c[i] = v.c[i];
        q0.push_back(e);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i0.a_in[i*4 +: 4] = 4'(v.a[i]);
            i0.w_in[i*4 +: 4] = 4'(v.w[i]);
        end
        i0.start = 1'b1;
        @(posedge clk); #1;
        i0.start = 1'b0;
        cyc = 1;
        mx  = 0;
        while (!i0.out_valid && cyc < 100) begin
            if (i0.busy && int'(i0.cnt_out) > mx) mx = int'(i0.cnt_out);
            @(posedge clk); #1;
            cyc++;
        end
        chk("u0_latency", cyc, v.lat);
        if (v.lat > 1) chk("u0_cnt_max", mx, v.lat - 2);
        e = q0.pop_front();
        for (int i = 0; i < 4; i++)
            chk($sformatf("u0_c%0d", i), i0.c_out[i*9 +: 9], e.c[i]);
        if (!hold) begin
            @(posedge clk); #1;
            chk("u0_ready_after", i0.ready, 1);
        end
    endtask

    task automatic run1();
        int w1[4];
        int c1[4];
        int a1[4];
        int cyc;
        int mx;
        a1 = '{3, 0, 0, 3};
        w1 = '{-2, 5, 7, -8};
        c1 = '{-6, 15, 21, -24};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i1.a_in[i*4 +: 4] = 4'(a1[i]);
            i1.w_in[i*4 +: 4] = 4'(w1[i]);
        end
        i1.start = 1'b1;
        @(posedge clk); #1;
        i1.start = 1'b0;
        cyc = 1;
        mx  = 0;
        while (!i1.out_valid && cyc < 100) begin
            if (i1.busy && int'(i1.cnt_out) > mx) mx = int'(i1.cnt_out);
            @(posedge clk); #1;
            cyc++;
        end
        chk("u1_latency", cyc, 16);
        chk("u1_cnt_max", mx, 14);
        for (int i = 0; i < 4; i++)
            chk($sformatf("u1_c%0d", i), $signed(i1.c_out[i*10 +: 10]), c1[i]);
    endtask

    task automatic run2(input int n);
        int   a[15];
        int   w[20];
        int   mxa;
        int   cyc;
        bit   seen;
        bit   done;
        exp_t e;
        mxa = 0;
        for (int i = 0; i < 15; i++) begin
            a[i] = (n % 16 == 0) ? 0 : int'($urandom_range(0, 63));
            if (a[i] > mxa) mxa = a[i];
        end
        for (int i = 0; i < 20; i++) begin
            w[i] = int'($urandom_range(0, 31));
            if (w[i] >= 16) w[i] -= 32;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                e.c[r*4+c] = 0;
                for (int k = 0; k < 5; k++)
                    e.c[r*4+c] += a[r*5+k] * w[k*4+c];
            end
        q2.push_back(e);
        cyc = 0;
        while (!i2.ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        for (int i = 0; i < 15; i++) i2.a_in[i*6 +: 6] = 6'(a[i]);
        for (int i = 0; i < 20; i++) i2.w_in[i*5 +: 5] = 5'(w[i]);
        i2.start = 1'b1;
        @(posedge clk); #1;
        i2.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            i2.out_ready = 1'($urandom_range(0, 1));
            if (i2.out_valid) begin
                if (!seen) begin
                    chk("u2_latency", cyc, mxa + 1);
                    seen = 1'b1;
                end
                if (i2.out_ready) begin
                    e = q2.pop_front();
                    for (int i = 0; i < 12; i++)
                        chk($sformatf("u2_m%0d_c%0d", n, i),
                            $signed(i2.c_out[i*15 +: 15]), e.c[i]);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) chk($sformatf("u2_m%0d_timeout", n), 0, 1);
    endtask

    initial begin
        tbl[0] = '{a: '{1, 2, 3, 4},     w: '{5, 6, 7, 8},
                   c: '{19, 22, 43, 50}, lat: 5};
        tbl[1] = '{a: '{15, 15, 15, 15}, w: '{15, 15, 15, 15},
                   c: '{450, 450, 450, 450}, lat: 16};
        tbl[2] = '{a: '{2, 0, 1, 1},     w: '{3, 1, 4, 2},
                   c: '{6, 2, 7, 3},     lat: 3};
        tbl[3] = '{a: '{0, 0, 0, 0},     w: '{9, 3, 12, 7},
                   c: '{0, 0, 0, 0},     lat: 1};

        i0.start = 0; i0.out_ready = 1; i0.a_in = '0; i0.w_in = '0;
        i1.start = 0; i1.out_ready = 1; i1.a_in = '0; i1.w_in = '0;
        i2.start = 0; i2.out_ready = 1; i2.a_in = '0; i2.w_in = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", i0.ready, 1);
        chk("rst_out_valid", i0.out_valid, 0);
        chk("rst_busy", i0.busy, 0);
        chk("rst_cnt", i0.cnt_out, 0);
        chk("rst_c_out", i0.c_out, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) run0(tbl[t], 1'b0);

        // Back-pressure: result must hold and new starts must be dropped
        i0.out_ready = 1'b0;
        run0(tbl[0], 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i0.start = 1'b1;
            i0.a_in  = 16'h7777;
            @(posedge clk); #1;
            chk("bp_valid", i0.out_valid, 1);
            chk("bp_ready", i0.ready, 0);
            chk("bp_c_out", i0.c_out, {9'd50, 9'd43, 9'd22, 9'd19});
        end
        @(negedge clk);
        i0.start     = 1'b0;
        i0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", i0.ready, 1);
        chk("bp_release_valid", i0.out_valid, 0);
        chk("bp_release_hold", i0.c_out, {9'd50, 9'd43, 9'd22, 9'd19});

        // Reset in the third RUN cycle of the basic case
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i0.a_in[i*4 +: 4] = 4'(tbl[0].a[i]);
            i0.w_in[i*4 +: 4] = 4'(tbl[0].w[i]);
        end
        i0.start = 1'b1;
        @(posedge clk); #1;
        i0.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready", i0.ready, 1);
        chk("mid_rst_valid", i0.out_valid, 0);
        chk("mid_rst_c_out", i0.c_out, 0);
        chk("mid_rst_cnt", i0.cnt_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run0(tbl[0], 1'b0);

        run1();

        for (int n = 0; n < 500; n++) run2(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
